sdram_ram_arb: RTL

- Two-requester arbiter on the simple word-level RAM interface between AXI front ends and sdram_axi_core.
- Lets two independent AXI-to-RAM bridges share one SDRAM core.
- Uses round-robin grant with burst lock.
- Routes each ack and its read data back to the issuing port through an in-order tag FIFO.

---
 rtl/sdram_ram_arb.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sdram_ram_arb.sv
// Two-port round-robin arbiter with burst lock in front of one SDRAM core.
// Each response goes back to the port that issued the request, using an in-order tag FIFO.
module sdram_ram_arb #(
    parameter int TAG_DEPTH = 4,
    parameter int TAG_W     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  inport0_wr_i,
    input  logic        inport0_rd_i,
    input  logic [7:0]  inport0_len_i,
    input  logic [31:0] inport0_addr_i,
    input  logic [31:0] inport0_write_data_i,
    output logic        inport0_accept_o,
    output logic        inport0_ack_o,
    output logic        inport0_error_o,
    output logic [31:0] inport0_read_data_o,
    input  logic [3:0]  inport1_wr_i,
    input  logic        inport1_rd_i,
    input  logic [7:0]  inport1_len_i,
    input  logic [31:0] inport1_addr_i,
    input  logic [31:0] inport1_write_data_i,
    output logic        inport1_accept_o,
    output logic        inport1_ack_o,
    output logic        inport1_error_o,
    output logic [31:0] inport1_read_data_o,
    output logic [3:0]  outport_wr_o,
    output logic        outport_rd_o,
    output logic [7:0]  outport_len_o,
    output logic [31:0] outport_addr_o,
    output logic [31:0] outport_write_data_o,
    input  logic        outport_accept_i,
    input  logic        outport_ack_i,
    input  logic        outport_error_i,
    input  logic [31:0] outport_read_data_i
);
    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(TAG_DEPTH);

    state_t           state_reg, state_next;
    logic             owner_reg, owner_next;
    logic [7:0]       beats_left_reg, beats_left_next;
    logic             last_grant_reg, last_grant_next;
    logic             tag_reg [TAG_DEPTH];
    logic [TAG_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [TAG_W:0]   count_reg;

    logic req0, req1, full, grant, fwd, push, pop, head;

    assign req0 = (inport0_wr_i != 4'd0) | inport0_rd_i;
    assign req1 = (inport1_wr_i != 4'd0) | inport1_rd_i;
    assign full = (count_reg == FULL_COUNT);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg      <= IDLE;
            owner_reg      <= 1'b0;
            beats_left_reg <= 8'd0;
            last_grant_reg <= 1'b1;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            beats_left_reg <= beats_left_next;
            last_grant_reg <= last_grant_next;
        end
    end

    always_comb begin
        state_next           = state_reg;
        owner_next           = owner_reg;
        beats_left_next      = beats_left_reg;
        last_grant_next      = last_grant_reg;
        grant                = owner_reg;
        fwd                  = 1'b0;
        outport_wr_o         = 4'd0;
        outport_rd_o         = 1'b0;
        outport_len_o        = 8'd0;
        outport_addr_o       = 32'd0;
        outport_write_data_o = 32'd0;
        inport0_accept_o     = 1'b0;
        inport1_accept_o     = 1'b0;

        case (state_reg)
            IDLE: begin
                // Tie goes to the port that did not win last time.
                grant = (req0 & req1) ? ~last_grant_reg : req1;
                fwd   = (req0 | req1) & ~full;
            end
            LOCKED: begin
                grant = owner_reg;
                fwd   = (owner_reg ? req1 : req0) & ~full;
            end
            default: ;
        endcase

        if (fwd) begin
            if (grant) begin
                outport_wr_o         = inport1_wr_i;
                outport_rd_o         = inport1_rd_i;
                outport_len_o        = inport1_len_i;
                outport_addr_o       = inport1_addr_i;
                outport_write_data_o = inport1_write_data_i;
                inport1_accept_o     = outport_accept_i;
            end else begin
                outport_wr_o         = inport0_wr_i;
                outport_rd_o         = inport0_rd_i;
                outport_len_o        = inport0_len_i;
                outport_addr_o       = inport0_addr_i;
                outport_write_data_o = inport0_write_data_i;
                inport0_accept_o     = outport_accept_i;
            end
        end

        push = fwd & outport_accept_i;

        if (push) begin
            if (state_reg == IDLE) begin
                last_grant_next = grant;
                if (outport_len_o != 8'd0) begin
                    state_next      = LOCKED;
                    owner_next      = grant;
                    beats_left_next = outport_len_o;
                end
            end else begin
                beats_left_next = beats_left_reg - 8'd1;
                if (beats_left_reg == 8'd1)
                    state_next = IDLE;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < TAG_DEPTH; gi++) begin : g_tag
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i)
                    tag_reg[gi] <= 1'b0;
                else if (push && (wr_ptr_reg == TAG_W'(gi)))
                    tag_reg[gi] <= grant;
            end
        end
    endgenerate

    // Acks with no outstanding tag are dropped and leave the pointers alone.
    assign pop  = outport_ack_i & (count_reg != '0);
    assign head = tag_reg[rd_ptr_reg];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
        end
    end

    assign inport0_ack_o       = pop & ~head;
    assign inport1_ack_o       = pop & head;
    assign inport0_error_o     = inport0_ack_o & outport_error_i;
    assign inport1_error_o     = inport1_ack_o & outport_error_i;
    assign inport0_read_data_o = inport0_ack_o ? outport_read_data_i : 32'd0;
    assign inport1_read_data_o = inport1_ack_o ? outport_read_data_i : 32'd0;

endmodule
